// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: default timing, FSM state type and frame length.
// Frame length depends on the UART_TX_PARITY_EN macro.
package uart_pkg;

  localparam int BPS_CNT_DEF = 868;
  localparam int BYTES_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 frame sender (optional even parity via UART_TX_PARITY_EN).
// start loads a byte; done flags the final cycle of the stop bit so a follow-on byte can chain.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BPS_CNT = BPS_CNT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int BW = $clog2(BPS_CNT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BPS_CNT - 1);

  tx_state_t   state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [7:0]  sh, sh_next;
  logic        tx_q, tx_next;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_next;
`endif

  assign bit_end = (baud == BAUD_LAST);
  assign tx      = tx_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_cnt;
    sh_next    = sh;
    tx_next    = tx_q;
    done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_q;
`endif
    if (state != IDLE) baud_next = bit_end ? '0 : baud + BW'(1);

    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (start) begin
          state_next = START;
          tx_next    = 1'b0;
          sh_next    = data;
`ifdef UART_TX_PARITY_EN
          par_next   = ^data;
`endif
        end
      end
      START: if (bit_end) begin
        state_next = DATA;
        tx_next    = sh[0];
        bit_next   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_cnt == 3'd7) begin
          bit_next = '0;
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
          tx_next    = par_q;
`else
          state_next = STOP;
          tx_next    = 1'b1;
`endif
        end else begin
          bit_next = bit_cnt + 3'd1;
          sh_next  = {1'b0, sh[7:1]};
          tx_next  = sh[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_next = STOP;
        tx_next    = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        done = 1'b1;
        // Chaining straight into the next start bit keeps bytes of a word gap-free.
        if (start) begin
          state_next = START;
          tx_next    = 1'b0;
          sh_next    = data;
`ifdef UART_TX_PARITY_EN
          par_next   = ^data;
`endif
        end else begin
          state_next = IDLE;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_cnt <= bit_next;
      tx_q    <= tx_next;
    end
  end

  // NOTE: pure datapath registers are left unreset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    sh <= sh_next;
`ifdef UART_TX_PARITY_EN
    par_q <= par_next;
`endif
  end

endmodule

// File: rtl/uart_tx.sv
// Word-level UART transmitter: sends BYTES 8N1 frames per handshake, LSB byte first.
// Optional even parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter  int BPS_CNT    = BPS_CNT_DEF,
  parameter  int BYTES      = BYTES_DEF,
  localparam int DATA_WIDTH = 8 * BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  tx,
  output logic                  busy,
  output logic                  Done
);

  localparam int IW = $clog2(BYTES) + 1;

  logic [DATA_WIDTH-1:0] word_q;
  logic [IW-1:0]         byte_idx;
  logic                  start_q, ready_q, busy_q, done_q;
  logic                  accept, last_byte, byte_start, byte_done;

  assign accept     = valid_in & ready_q;
  assign last_byte  = (byte_idx == IW'(BYTES - 1));
  assign byte_start = start_q | (byte_done & ~last_byte);

  assign ready_out = ready_q;
  assign busy      = busy_q;
  assign Done      = done_q;

  uart_tx_byte #(.BPS_CNT(BPS_CNT)) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (word_q[7:0]),
    .tx    (tx),
    .done  (byte_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      byte_idx <= '0;
    end else begin
      start_q <= accept;
      done_q  <= byte_done & last_byte;
      if (accept) begin
        ready_q  <= 1'b0;
        busy_q   <= 1'b1;
        byte_idx <= '0;
      end else if (byte_done) begin
        if (last_byte) begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          byte_idx <= byte_idx + IW'(1);
        end
      end
    end
  end

  // The sender grabs word_q[7:0] as each byte starts, so the word shifts down on every start.
  always_ff @(posedge clk) begin
    if (accept)          word_q <= data_in;
    else if (byte_start) word_q <= word_q >> 8;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle model comparison plus directed frame decodes.
// Honours UART_TX_PARITY_EN to match the DUT build.
module tb_uart_tx;

  localparam int BPS   = 4;
  localparam int BYTES = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
  localparam bit PAR = 1'b1;
  localparam int DONE_LIT = 177;
`else
  localparam int F = 10;
  localparam bit PAR = 1'b0;
  localparam int DONE_LIT = 161;
`endif
  localparam int WORD_CYC = BYTES * F * BPS;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out, tx, busy, Done;

  int errors = 0;
  int checks = 0;

  uart_tx #(.BPS_CNT(BPS), .BYTES(BYTES)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx        (tx),
    .busy      (busy),
    .Done      (Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the expected line level is derived from the frame layout directly.
  function automatic logic wave_bit(input logic [31:0] w, input int i);
    int byte_i, pos;
    logic [7:0] b;
    byte_i = i / (F * BPS);
    pos    = (i % (F * BPS)) / BPS;
    b      = w[8*byte_i +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (PAR && pos == 9) return ^b;
    return 1'b1;
  endfunction

  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_n      = 0;
  logic [31:0] m_word   = '0;
  bit          started  = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_n      <= 0;
    end else if (!m_active && valid_in) begin
      m_active <= 1'b1;
      m_n      <= 0;
      m_word   <= data_in;
      m_done   <= 1'b0;
    end else if (m_active) begin
      m_done <= 1'b0;
      if (m_n == WORD_CYC) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_n <= m_n + 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic exp_tx;
      exp_tx = (m_active && m_n > 0) ? wave_bit(m_word, m_n - 1) : 1'b1;
      check("cyc_tx",    32'(tx),        32'(exp_tx));
      check("cyc_ready", 32'(ready_out), 32'(!m_active));
      check("cyc_busy",  32'(busy),      32'(m_active));
      check("cyc_done",  32'(Done),      32'(m_done));
    end
  end

  logic tx_log [0:511];
  int   done_at;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a handshake edge; k=0 is the cycle before the start bit.
  task automatic capture(output int d);
    d = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      tx_log[k] = tx;
      if (Done === 1'b1) begin
        d = k;
        break;
      end
    end
  endtask

  task automatic send(input logic [31:0] w, output int d);
    check("ready_before_send", 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    data_in  = w;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in  = 32'h0BAD_F00D;
    capture(d);
  endtask

  task automatic check_word(input string tag, input logic [31:0] w);
    for (int b = 0; b < BYTES; b++) begin
      int base;
      logic [7:0] d;
      base = 1 + b * F * BPS + BPS / 2;
      for (int i = 0; i < 8; i++) d[i] = tx_log[base + (1 + i) * BPS];
      check($sformatf("%s_b%0d_start", tag, b), 32'(tx_log[base]), 32'd0);
      check($sformatf("%s_b%0d_data", tag, b), 32'(d), 32'(w[8*b +: 8]));
      check($sformatf("%s_b%0d_stop", tag, b), 32'(tx_log[base + (F - 1) * BPS]), 32'd1);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  int a5_bits [0:10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
  int a5_bits [0:9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tx",    32'(tx),        32'd1);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(Done),      32'd0);

    // 0x000000A5: literal bit pattern of byte 0, zero frames after, Done latency.
    step();
    send(32'h0000_00A5, done_at);
    check("a5_done_cycle", done_at, DONE_LIT);
    for (int i = 0; i < F; i++)
      check($sformatf("a5_bit%0d", i), 32'(tx_log[1 + i * BPS + BPS / 2]), a5_bits[i]);
    for (int i = 0; i < F * BPS; i++)
      check("a5_start_low_cycle", 32'(tx_log[1 + i]), 32'(a5_bits[i / BPS]));
    check_word("a5", 32'h0000_00A5);

    // Byte order on the line is LSB byte first.
    step();
    send(32'h1234_5678, done_at);
    check("w1234_done_cycle", done_at, DONE_LIT);
    check_word("w1234", 32'h1234_5678);

    // valid_in held: second word accepted exactly in the Done cycle of the first.
    step();
    valid_in = 1'b1;
    data_in  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 data_in = 32'hCAFE_F00D;
    capture(done_at);
    check("dead_done_cycle", done_at, DONE_LIT);
    check_word("dead", 32'hDEAD_BEEF);
    check("dead_ready_in_done", 32'(ready_out), 32'd1);
    @(posedge clk);
    #1 valid_in = 1'b0;
    data_in = 32'h0BAD_F00D;
    capture(done_at);
    check("cafe_idle_first", 32'(tx_log[0]), 32'd1);
    check("cafe_start_next", 32'(tx_log[1]), 32'd0);
    check("cafe_done_cycle", done_at, DONE_LIT);
    check_word("cafe", 32'hCAFE_F00D);

    // valid_in pulse while busy must be ignored.
    step();
    valid_in = 1'b1;
    data_in  = 32'h5A3C_0F81;
    @(posedge clk);
    #1 valid_in = 1'b0;
    fork
      capture(done_at);
      begin
        repeat (50) @(posedge clk);
        #1 valid_in = 1'b1;
        data_in = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 valid_in = 1'b0;
      end
    join
    check("busy_pulse_done_cycle", done_at, DONE_LIT);
    check_word("busy_pulse", 32'h5A3C_0F81);

    // Reset during data bit 3 of byte 1.
    step();
    valid_in = 1'b1;
    data_in  = 32'h0000_FF00;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (1 + (F + 4) * BPS + 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_tx",    32'(tx),        32'd1);
    check("midrst_ready", 32'(ready_out), 32'd1);
    check("midrst_busy",  32'(busy),      32'd0);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (Done === 1'b1) seen++;
    end
    check("midrst_no_done", seen, 0);
    step();
    send(32'h0F1E_2D3C, done_at);
    check("after_rst_done_cycle", done_at, DONE_LIT);
    check_word("after_rst", 32'h0F1E_2D3C);

`ifdef UART_TX_PARITY_EN
    step();
    send(32'h0000_0001, done_at);
    check("par_done_cycle", done_at, 177);
    check("par_b0", 32'(tx_log[1 + 9 * BPS + BPS / 2]), 32'd1);
    for (int b = 1; b < BYTES; b++)
      check($sformatf("par_b%0d", b), 32'(tx_log[1 + (b * F + 9) * BPS + BPS / 2]), 32'd0);
    check_word("par", 32'h0000_0001);
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the board UART link. Accepts one `DATA_WIDTH` word per valid/ready handshake and shifts it out on `tx` as `BYTES` consecutive 8N1 frames, least-significant byte first, at one bit per `BPS_CNT` clocks. Sits beside the receiver in the IO subsystem and drives the host-facing TX pin, for example to return memory dumps or status words.

## Interface
- `BPS_CNT`, 868, clocks per bit (100 MHz / 115200); must be ≥ 2.
- `BYTES`, 4, bytes per word; `DATA_WIDTH` = 8·`BYTES`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  `DATA_WIDTH`  word to send; sampled only at handshake.
- `valid_in`  in  1  word available.
- `ready_out`  out  1  high when a word can be accepted; reset 1.
- `tx`  out  1  serial line, idle high; registered output; reset 1.
- `busy`  out  1  high from handshake until the last stop bit ends; reset 0.
- `Done`  out  1  one-cycle pulse after the last stop bit of a word; reset 0.

## Operation
- Handshake: a word is accepted on an edge where `valid_in & ready_out`. It is latched into a shift register, byte index = 0, and `ready_out` = 0, `busy` = 1 from the next cycle.
- `valid_in` while `ready_out` = 0 is ignored. No buffering beyond the one latched word.
- FSM states: IDLE → START → DATA → (PARITY) → STOP → START (more bytes) or IDLE.
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - DATA: bits 0..7 of the current byte, LSB first.
  - STOP: `tx` = 1.
- Baud counter: runs 0..`BPS_CNT`−1 in every non-IDLE state. A state or bit advances when the counter = `BPS_CNT`−1, then the counter wraps to 0. The bit counter is 0..7 in DATA.
- After STOP of byte k < `BYTES`−1: go straight to START of byte k+1, with no idle gap.
- After STOP of the last byte: enter IDLE. `Done` = 1 for that one cycle, `ready_out` = 1 and `busy` = 0 in the same cycle.
- A handshake in the `Done` cycle is legal. Its start bit begins on the next cycle, so consecutive words are sent back-to-back.
- Reset mid-frame: on the next edge `tx` = 1, all counters = 0, FSM = IDLE, `ready_out` = 1. The latched word is discarded and no `Done` pulse is issued.

## Timing
- Handshake edge → `tx` falls at the next edge. This is the first cycle of the start bit.
- Every bit, including start, stop and parity, lasts exactly `BPS_CNT` cycles.
- Frame length F = 10 bits (11 with parity). Word duration = `BYTES`·F·`BPS_CNT` cycles.
- `Done` is asserted the cycle after the final stop-bit cycle, i.e. `BYTES`·F·`BPS_CNT`+1 cycles after the handshake edge.
- Width rules:
  - baud counter: $clog2(`BPS_CNT`) bits.
  - bit counter: 3 bits.
  - byte index: $clog2(`BYTES`)+1 bits.
  - No counter wraps outside its stated range.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for `BPS_CNT` cycles, so F = 11.
- Macro undefined: no PARITY state, F = 10. Parity logic is absent from the netlist.
- The matching receiver must be built with the same setting.

## Structure
- Shared package `uart_pkg`:
  - default `BPS_CNT` and `BYTES`.
  - `tx_state_t` enum {IDLE, START, DATA, PARITY, STOP}. PARITY is present regardless of the macro.
  - frame-length localparam derived from `UART_TX_PARITY_EN`.
- One sub-module, `uart_tx_byte`:
  - Sends a single byte frame with a start/done pulse interface.
  - Owns the baud counter, bit counter and `tx` register.
- The top level owns the word register, byte index, handshake, `busy` and `Done`.

## Test plan
- `BPS_CNT`=4, parity off, send 0x000000A5.
  - Byte 0 on `tx`: 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles.
  - Bytes 1–3: 0x00 frames.
  - `Done` at cycle 161 after the handshake.
- Send 0x12345678: decoded byte order on `tx` is 78, 56, 34, 12, with no idle cycles between frames.
- Hold `valid_in`=1 with 0xDEADBEEF, then 0xCAFEF00D: the second word is accepted exactly in the `Done` cycle of the first, and its start bit follows on the next cycle.
- Pulse `valid_in` with 0xFFFFFFFF while `busy`: the word is ignored and the in-flight word completes unchanged.
- Assert `reset` during bit 3 of byte 1: `tx`=1 and `ready_out`=1 after one edge, no `Done` is issued, and the next word transmits correctly.
- With `UART_TX_PARITY_EN`, send 0x00000001: byte 0 parity bit = 1, bytes 1–3 parity bits = 0, and `Done` at cycle 4·11·4+1 = 177.
